// File: rtl/rf_wb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter_pkg
//   Shared widths, arbiter state encoding and a small sizing helper for the
//   register-file writeback arbiter and its busy-register scoreboard.
// ---------------------------------------------------------------------------
package rf_wb_arbiter_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int DATA_WIDTH     = 32;

  // S_PRIO0 is the normal mode (pipeline first); S_PRIO1 is the one-cycle
  // forced grant to the long-latency unit after it has starved.
  typedef enum logic {
    S_PRIO0 = 1'b0,
    S_PRIO1 = 1'b1
  } arb_state_e;

  // Bits needed to hold 0..max inclusive; never narrower than one bit.
  function automatic int cnt_width(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// ---------------------------------------------------------------------------
// rf_scoreboard
//   Busy vector for registers that have an outstanding long-latency write.
//   A bit is set when the op is issued and cleared when its writeback is
//   granted. Register 0 is never marked busy.
//
// Ports
//   clk       in   clock
//   rst       in   asynchronous active-high reset, clears every busy bit
//   set_en    in   issue strobe
//   set_addr  in   destination register of the issued op
//   clr_en    in   writeback grant strobe
//   clr_addr  in   destination register of the granted writeback
//   qry_addr  in   register to look up
//   qry_busy  out  combinational busy bit of qry_addr
// ---------------------------------------------------------------------------
module rf_scoreboard #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] qry_addr,
  output logic              qry_busy
);

  localparam int NREG = 2 ** ADDR_W;

  logic [NREG-1:0] busy;

  // The set is written after the clear so that a reissue to the register
  // being retired in the same cycle keeps it busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (clr_en) begin
        busy[clr_addr] <= 1'b0;
      end
      if (set_en && (set_addr != '0)) begin
        busy[set_addr] <= 1'b1;
      end
    end
  end

  // busy[0] can never be set, so register 0 always reads idle.
  assign qry_busy = busy[qry_addr];

endmodule

// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
//   Shares the register file's single write port between the in-order
//   pipeline writeback (port 0) and the long-latency unit (port 1).
//   Port 0 has fixed priority; a starvation counter forces a port-1 grant
//   after STARVE_MAX consecutive denied cycles. Write outputs are registered
//   (grant in cycle N -> rf_* in cycle N+1). Writes to register 0 complete
//   the handshake but never raise rf_wen.
//
// Configuration
//   RF_WB_SCOREBOARD_EN  when defined, a busy-register scoreboard tracks
//                        issued port-1 destinations and answers qry_busy;
//                        when undefined, qry_busy is 0 and p1_iss_* and
//                        qry_addr are ignored. The port list is identical.
//
// Ports
//   clk           in   clock
//   rst           in   asynchronous active-high reset
//   p0_valid      in   pipeline WB write request
//   p0_addr       in   pipeline WB destination register
//   p0_data       in   pipeline WB write data
//   p0_ready      out  port-0 grant this cycle (combinational)
//   p1_valid      in   long-latency write request
//   p1_addr       in   long-latency destination register
//   p1_data       in   long-latency write data
//   p1_ready      out  port-1 grant this cycle (combinational)
//   p1_iss_valid  in   long-latency op issued (scoreboard set)
//   p1_iss_addr   in   destination register of the issued op
//   qry_addr      in   scoreboard query address
//   qry_busy      out  qry_addr has an outstanding port-1 write
//   rf_wen        out  register file write enable (registered)
//   rf_waddr      out  register file write address (registered)
//   rf_wdata      out  register file write data (registered)
//
// FSM states
//   state   | meaning
//   S_PRIO0 | port 0 wins any conflict; port 1 only when port 0 is idle
//   S_PRIO1 | port 1 starved; it wins this cycle and port 0 stalls
// ---------------------------------------------------------------------------
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int ADDR_W     = REG_ADDR_WIDTH,
  parameter int DATA_W     = DATA_WIDTH,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_valid,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_data,
  output logic              p0_ready,
  input  logic              p1_valid,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_data,
  output logic              p1_ready,
  input  logic              p1_iss_valid,
  input  logic [ADDR_W-1:0] p1_iss_addr,
  input  logic [ADDR_W-1:0] qry_addr,
  output logic              qry_busy,
  output logic              rf_wen,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  localparam int                CNT_W   = cnt_width(STARVE_MAX);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_MAX);

  arb_state_e       state;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_cnt_nxt;
  logic             p0_gnt;
  logic             p1_gnt;

  // Grant decode. At most one grant, and a grant never appears without
  // the matching valid.
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (state == S_PRIO1) begin
      p1_gnt = p1_valid;
      p0_gnt = p0_valid & ~p1_valid;
    end else begin
      p0_gnt = p0_valid;
      p1_gnt = p1_valid & ~p0_valid;
    end
  end

  assign p0_ready = p0_gnt;
  assign p1_ready = p1_gnt;

  // Counts consecutive denied port-1 cycles; any grant or withdrawal
  // restarts the count.
  always_comb begin
    starve_cnt_nxt = '0;
    if (p1_valid && !p1_gnt) begin
      starve_cnt_nxt = (starve_cnt == CNT_MAX) ? CNT_MAX : starve_cnt + 1'b1;
    end
  end

  // Priority flips on the edge where the count reaches STARVE_MAX, so the
  // forced grant lands in the very next cycle (denied STARVE_MAX cycles,
  // granted on the following one).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_PRIO0;
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_cnt_nxt;
      case (state)
        S_PRIO0: begin
          if (starve_cnt_nxt == CNT_MAX) begin
            state <= S_PRIO1;
          end
        end
        S_PRIO1: begin
          if (p1_gnt || !p1_valid) begin
            state <= S_PRIO0;
          end
        end
        default: state <= S_PRIO0;
      endcase
    end
  end

  // Address/data are captured on every grant; the enable is suppressed for
  // register 0 so the write is dropped while the handshake still completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_wen <= 1'b0;
      if (p0_gnt) begin
        rf_wen   <= (p0_addr != '0);
        rf_waddr <= p0_addr;
        rf_wdata <= p0_data;
      end else if (p1_gnt) begin
        rf_wen   <= (p1_addr != '0);
        rf_waddr <= p1_addr;
        rf_wdata <= p1_data;
      end
    end
  end

`ifdef RF_WB_SCOREBOARD_EN
  rf_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (p1_iss_valid),
    .set_addr (p1_iss_addr),
    .clr_en   (p1_gnt),
    .clr_addr (p1_addr),
    .qry_addr (qry_addr),
    .qry_busy (qry_busy)
  );
`else
  logic unused_sb_inputs;
  assign unused_sb_inputs = ^{p1_iss_valid, p1_iss_addr, qry_addr};
  assign qry_busy         = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int SMAX = 4;

  logic          clk;
  logic          rst;
  logic          p0_valid;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_data;
  logic          p0_ready;
  logic          p1_valid;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_data;
  logic          p1_ready;
  logic          p1_iss_valid;
  logic [AW-1:0] p1_iss_addr;
  logic [AW-1:0] qry_addr;
  logic          qry_busy;
  logic          rf_wen;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  rf_wb_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .STARVE_MAX (SMAX)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .p0_valid     (p0_valid),
    .p0_addr      (p0_addr),
    .p0_data      (p0_data),
    .p0_ready     (p0_ready),
    .p1_valid     (p1_valid),
    .p1_addr      (p1_addr),
    .p1_data      (p1_data),
    .p1_ready     (p1_ready),
    .p1_iss_valid (p1_iss_valid),
    .p1_iss_addr  (p1_iss_addr),
    .qry_addr     (qry_addr),
    .qry_busy     (qry_busy),
    .rf_wen       (rf_wen),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  // Reference model: how long port 1 has been waiting, what the RF write
  // port should show, and which registers have outstanding port-1 writes.
  int            wait_cycles;
  logic          m_wen;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  bit            m_known;
  logic [31:0]   m_busy;
  bit            g0;
  bit            g1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_qry();
`ifdef RF_WB_SCOREBOARD_EN
    return (qry_addr != 0) && m_busy[qry_addr];
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    wait_cycles = 0;
    m_wen       = 1'b0;
    m_waddr     = '0;
    m_wdata     = '0;
    m_known     = 1'b1;
    m_busy      = '0;
  endtask

  // Port 1 wins once it has waited SMAX cycles in a row; otherwise port 0.
  task automatic model_grants();
    bit p1_first;
    p1_first = (wait_cycles >= SMAX);
    g1 = p1_valid && (p1_first || !p0_valid);
    g0 = p0_valid && !(p1_first && p1_valid);
  endtask

  task automatic drive(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic iv, input logic [AW-1:0] ia, input logic [AW-1:0] qa);
    p0_valid = v0; p0_addr = a0; p0_data = d0;
    p1_valid = v1; p1_addr = a1; p1_data = d1;
    p1_iss_valid = iv; p1_iss_addr = ia; qry_addr = qa;
  endtask

  // One clock: compare at the falling edge, then advance the model just
  // after the rising edge (inputs unchanged until the caller drives again).
  task automatic step(input string tag);
    @(negedge clk);
    model_grants();
    chk({tag, ".p0_ready"}, 64'(p0_ready), 64'(g0));
    chk({tag, ".p1_ready"}, 64'(p1_ready), 64'(g1));
    chk({tag, ".rf_wen"},   64'(rf_wen),   64'(m_wen));
    if (m_known) begin
      chk({tag, ".rf_waddr"}, 64'(rf_waddr), 64'(m_waddr));
      chk({tag, ".rf_wdata"}, 64'(rf_wdata), 64'(m_wdata));
    end
    chk({tag, ".qry_busy"}, 64'(qry_busy), 64'(exp_qry()));
    @(posedge clk);
    #1;
    m_wen = 1'b0;
    if (g0 || g1) begin
      m_wen   = g0 ? (p0_addr != 0) : (p1_addr != 0);
      m_waddr = g0 ? p0_addr : p1_addr;
      m_wdata = g0 ? p0_data : p1_data;
      m_known = m_wen;
    end
    if (p1_valid && !g1) wait_cycles = (wait_cycles < SMAX) ? wait_cycles + 1 : SMAX;
    else                 wait_cycles = 0;
    if (g1) m_busy[p1_addr] = 1'b0;
    if (p1_iss_valid && p1_iss_addr != 0) m_busy[p1_iss_addr] = 1'b1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst.rf_wen",   64'(rf_wen),   64'h0);
    chk("rst.rf_waddr", 64'(rf_waddr), 64'h0);
    chk("rst.rf_wdata", 64'(rf_wdata), 64'h0);
    chk("rst.p0_ready", 64'(p0_ready), 64'h0);
    chk("rst.p1_ready", 64'(p1_ready), 64'h0);
    chk("rst.qry_busy", 64'(qry_busy), 64'h0);
    @(posedge clk);
    #1;

    // Simple port-0 write and its registered appearance.
    drive(1, 5, 32'hA5, 0, 0, 0, 0, 0, 0);
    step("p0_write");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("p0_result");
    step("idle_hold");

    // Both valid every cycle: four denials then a forced port-1 grant.
    drive(1, 3, 32'h1000, 1, 9, 32'hBEEF_0009, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      step($sformatf("starve%0d", i));
      if (g0) p0_data = p0_data + 1;
      if (g1) p1_valid = 1'b0;
    end

    // Two denials, withdrawal, then a fresh request needs four more denials.
    drive(1, 4, 32'h2000, 1, 10, 32'h0A0A_0A0A, 0, 0, 0);
    step("wd0");
    p0_data = p0_data + 1;
    step("wd1");
    p0_data = p0_data + 1;
    p1_valid = 1'b0;
    step("wd_drop");
    p0_data = p0_data + 1;
    p1_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step($sformatf("wd_again%0d", i));
      if (g0) p0_data = p0_data + 1;
      if (g1) p1_valid = 1'b0;
    end

    // Write to register 0 is accepted but dropped.
    drive(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0);
    step("a0_req");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("a0_result");

    // Scoreboard: issue, retire with same-cycle reissue, retire cleanly.
    drive(0, 0, 0, 0, 0, 0, 1, 7, 7);
    step("sb_issue");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 7);
    step("sb_busy");
    drive(0, 0, 0, 1, 7, 32'h7777, 1, 7, 7);
    step("sb_retire_reissue");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 7);
    step("sb_still_busy");
    drive(0, 0, 0, 1, 7, 32'h7778, 0, 0, 7);
    step("sb_retire");
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step("sb_clear_q0");
    qry_addr = 7;
    p1_iss_valid = 1'b0;
    step("sb_clear_q7");

    // Reset while port 1 holds the forced grant.
    drive(0, 0, 0, 0, 0, 0, 1, 7, 7);
    step("mr_issue");
    drive(1, 3, 32'h3000, 1, 7, 32'hC0DE_0007, 0, 0, 7);
    for (int i = 0; i < SMAX; i++) begin
      step($sformatf("mr_deny%0d", i));
      p0_data = p0_data + 1;
    end
    @(negedge clk);
    chk("mr.p1_ready", 64'(p1_ready), 64'h1);
    chk("mr.p0_ready", 64'(p0_ready), 64'h0);
    chk("mr.rf_wen_before", 64'(rf_wen), 64'h1);
    rst = 1'b1;
    #1;
    chk("mr.rf_wen",   64'(rf_wen),   64'h0);
    chk("mr.rf_waddr", 64'(rf_waddr), 64'h0);
    chk("mr.rf_wdata", 64'(rf_wdata), 64'h0);
    chk("mr.qry_busy", 64'(qry_busy), 64'h0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 7);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    drive(1, 2, 32'h4000, 1, 7, 32'hC0DE_0007, 0, 0, 7);
    step("mr_after");
    p0_valid = 1'b0;
    step("mr_after2");

    // Randomised traffic obeying the hold-until-ready handshake.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      step("rnd");
      if (!p0_valid || g0) begin
        p0_valid = ($urandom_range(0, 3) != 0);
        p0_addr  = AW'($urandom_range(0, 7));
        p0_data  = $urandom;
      end
      if (!p1_valid || g1) begin
        p1_valid = ($urandom_range(0, 1) != 0);
        p1_addr  = AW'($urandom_range(0, 7));
        p1_data  = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        p1_valid = 1'b0;
      end
      p1_iss_valid = ($urandom_range(0, 2) == 0);
      p1_iss_addr  = AW'($urandom_range(0, 7));
      qry_addr     = AW'($urandom_range(0, 7));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
